// File: rtl/audio_frame_packer.sv
// audio_frame_packer: buffers multi-channel sample frames in a FIFO and streams them
// as fixed-size byte packets (4-byte header plus masked, sign-extended samples).
module audio_frame_packer #(
    parameter int CH = 2,
    parameter int SAMPLE_W = 17,
    parameter int SAMPLES_PER_PKT = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [CH*SAMPLE_W-1:0]        in_data,
    input  logic [CH-1:0]                 ch_mask,
    input  logic                          clr_ovf,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof,
    output logic                          out_eof,
    output logic [15:0]                   out_len,
    output logic [$clog2(FIFO_DEPTH):0]   frame_level,
    output logic                          overflow
);
    localparam int BYTES = (SAMPLE_W + 7) / 8;
    localparam int EW = BYTES * 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int FW = $clog2(SAMPLES_PER_PKT) + 1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    logic [CH*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp, n_rd;
    state_t state;
    logic [CH-1:0] mask_q, mask_in;
    logic [7:0] seq, nch;
    logic [1:0] hidx;
    logic [CW-1:0] ch, n_ch, nc_idx, first;
    logic [BW-1:0] bidx, n_b;
    logic [FW-1:0] fcnt, n_fc;
    logic push, pop, nc_has, new_frame, n_eof;

    function automatic logic has_after(input logic [CH-1:0] m, input int c);
        has_after = 1'b0;
        for (int k = 0; k < CH; k++)
            if (m[k] && k > c) has_after = 1'b1;
    endfunction

    function automatic logic [CW-1:0] next_after(input logic [CH-1:0] m, input int c);
        next_after = '0;
        for (int k = CH - 1; k >= 0; k--)
            if (m[k] && k > c) next_after = CW'(k);
    endfunction

    function automatic logic [7:0] byte_of(input logic [CH*SAMPLE_W-1:0] f, input logic [CW-1:0] c,
                                           input logic [BW-1:0] b);
        logic signed [EW-1:0] e;
        e = EW'($signed(f[int'(c)*SAMPLE_W +: SAMPLE_W]));
        return e[int'(b)*8 +: 8];
    endfunction

    assign mask_in = ch_mask == '0 ? CH'(1) : ch_mask;
    assign push = in_valid && frame_level < LW'(FIFO_DEPTH);
    assign pop = out_valid && out_ready && state == PAYLOAD && bidx == '0 && !nc_has;

    // Position of the byte presented after the current one is accepted
    always_comb begin
        nc_has = has_after(mask_q, int'(ch));
        nc_idx = next_after(mask_q, int'(ch));
        first = next_after(mask_q, -1);
        new_frame = state == HDR || (bidx == '0 && !nc_has);
        n_fc = state == HDR ? '0 : new_frame ? fcnt + 1'b1 : fcnt;
        n_ch = new_frame ? first : bidx == '0 ? nc_idx : ch;
        n_b = (state == HDR || bidx == '0) ? BW'(BYTES - 1) : bidx - 1'b1;
        n_rd = (state == PAYLOAD && new_frame) ? rp + 1'b1 : rp;
        n_eof = n_fc == FW'(SAMPLES_PER_PKT - 1) && n_b == '0 && !has_after(mask_q, int'(n_ch));
    end

    always_ff @(posedge sys_clk)
        if (push) mem[wp] <= in_data;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            frame_level <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            frame_level <= frame_level + LW'(push) - LW'(pop);
            overflow <= (in_valid && !push) || (overflow && !clr_ovf);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_sof <= 1'b0;
            out_eof <= 1'b0;
            out_data <= '0;
            out_len <= '0;
            mask_q <= '0;
            nch <= '0;
            seq <= '0;
            hidx <= '0;
            ch <= '0;
            bidx <= '0;
            fcnt <= '0;
        end else if (state == IDLE) begin
            if (frame_level >= LW'(SAMPLES_PER_PKT)) begin
                state <= HDR;
                out_valid <= 1'b1;
                out_sof <= 1'b1;
                out_data <= 8'hA5;
                hidx <= '0;
                mask_q <= mask_in;
                nch <= 8'($countones(mask_in));
                out_len <= 16'(4 + SAMPLES_PER_PKT * $countones(mask_in) * BYTES);
            end
        end else if (out_ready) begin
            out_sof <= 1'b0;
            hidx <= hidx + 1'b1;
            if (state == HDR && hidx != 2'd3) begin
                out_data <= hidx == 2'd0 ? seq : hidx == 2'd1 ? nch : 8'(BYTES);
            end else if (out_eof) begin
                state <= IDLE;
                out_valid <= 1'b0;
                out_eof <= 1'b0;
                seq <= seq + 1'b1;
            end else begin
                state <= PAYLOAD;
                out_data <= byte_of(mem[n_rd], n_ch, n_b);
                out_eof <= n_eof;
                ch <= n_ch;
                bidx <= n_b;
                fcnt <= n_fc;
            end
        end
    end
endmodule

// File: tb/tb_audio_frame_packer.sv
// tb_audio_frame_packer: directed stimulus with an expected-byte scoreboard built from a
// frame model; a negedge monitor compares every accepted beat and checks stall stability.
module tb_audio_frame_packer;
    logic sys_clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clr_ovf = 1'b0, out_ready = 1'b1;
    logic [33:0] in_data = '0;
    logic [1:0] ch_mask = 2'b11;
    logic [7:0] out_data;
    logic out_valid, out_sof, out_eof, overflow;
    logic [15:0] out_len;
    logic [3:0] frame_level;

    typedef struct packed {logic [7:0] d; logic sof; logic eof; logic [15:0] len;} exp_t;
    exp_t exp_q[$];
    logic [33:0] mfifo[$];
    logic [7:0] seq_m = 8'd0;
    int total = 0, passed = 0, failed = 0;
    logic in_pkt = 1'b0, gap = 1'b0, hold_v = 1'b0, hold_s, hold_e;
    logic [7:0] hold_d;

    audio_frame_packer #(.CH(2), .SAMPLE_W(17), .SAMPLES_PER_PKT(4), .FIFO_DEPTH(8)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .ch_mask(ch_mask), .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof), .out_len(out_len),
        .frame_level(frame_level), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_sof"}, 32'(out_sof), 0);
        check({tag, "_eof"}, 32'(out_eof), 0);
        check({tag, "_data"}, 32'(out_data), 0);
        check({tag, "_len"}, 32'(out_len), 0);
        check({tag, "_level"}, 32'(frame_level), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    task automatic push_frame(input logic [16:0] a, input logic [16:0] b);
        in_data = {b, a};
        in_valid = 1'b1;
        if (mfifo.size() < 8) mfifo.push_back({b, a});
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
    endtask

    // Expected bytes of one packet, taken from the model FIFO with the given mask
    task automatic build_packet(input logic [1:0] mask);
        logic [1:0] m;
        int n;
        logic [33:0] fr;
        logic [23:0] s;
        logic [15:0] len;
        logic [7:0] hdr[4];
        exp_t t;
        m = mask == 2'b00 ? 2'b01 : mask;
        n = $countones(m);
        len = 16'(4 + 4 * n * 3);
        hdr = '{8'hA5, seq_m, 8'(n), 8'd3};
        for (int i = 0; i < 4; i++) exp_q.push_back('{hdr[i], i == 0, 1'b0, len});
        for (int f = 0; f < 4; f++) begin
            fr = mfifo.pop_front();
            for (int c = 0; c < 2; c++)
                if (m[c]) begin
                    s = {{7{fr[c*17+16]}}, fr[c*17 +: 17]};
                    for (int b = 2; b >= 0; b--) exp_q.push_back('{s[b*8 +: 8], 1'b0, 1'b0, len});
                end
        end
        t = exp_q.pop_back();
        t.eof = 1'b1;
        exp_q.push_back(t);
        seq_m++;
    endtask

    task automatic drain(input logic bp);
        for (int i = 0; i < 2000; i++) begin
            @(posedge sys_clk);
            #1 out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (exp_q.size() == 0) break;
        end
        check("drain_done", 32'(exp_q.size()), 0);
        out_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_sof();
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (out_valid && out_sof) break;
        end
        check("sof_seen", 32'(out_valid && out_sof), 1);
    endtask

    always @(negedge sys_clk) begin
        if (rst_n) begin
            exp_t e;
            if (gap) check("idle_gap", 32'(out_valid), 0);
            gap = 1'b0;
            if (hold_v) begin
                check("stall_data", 32'(out_data), 32'(hold_d));
                check("stall_flags", 32'({out_valid, out_sof, out_eof}), 32'({1'b1, hold_s, hold_e}));
            end
            if (in_pkt) check("valid_held", 32'(out_valid), 1);
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_s = out_sof;
            hold_e = out_eof;
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.d));
                    check("beat_sof_eof", 32'({out_sof, out_eof}), 32'({e.sof, e.eof}));
                    check("beat_len", 32'(out_len), 32'(e.len));
                end
                in_pkt = !out_eof;
                gap = out_eof;
            end
        end
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 check_reset("reset");
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        // Basic packet, both channels
        repeat (4) push_frame(17'h00001, 17'h1FFFF);
        build_packet(2'b11);
        drain(1'b0);
        check("level_after_pkt", 32'(frame_level), 0);
        // Channel 1 only; mask changes mid-packet must not matter
        ch_mask = 2'b10;
        for (int i = 0; i < 4; i++) push_frame(17'(i * 17'h1111 + 5), 17'(17'h10000 | i));
        build_packet(2'b10);
        wait_sof();
        ch_mask = 2'b01;
        drain(1'b0);
        // Empty mask behaves as channel 0 only
        ch_mask = 2'b00;
        for (int i = 0; i < 4; i++) push_frame(17'(17'h12345 + i), 17'(17'h0ABCD - i));
        build_packet(2'b00);
        drain(1'b0);
        // Random backpressure over two queued packets
        ch_mask = 2'b11;
        out_ready = 1'b0;
        repeat (4) push_frame(17'($urandom), 17'($urandom));
        build_packet(2'b11);
        repeat (4) push_frame(17'($urandom), 17'($urandom));
        build_packet(2'b11);
        drain(1'b1);
        check("level_after_bp", 32'(frame_level), 0);
        // Overflow with the output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_frame(17'(i), 17'(i + 100));
        check("ovf_level", 32'(frame_level), 8);
        check("ovf_set", 32'(overflow), 1);
        in_data = '1;
        in_valid = 1'b1;
        clr_ovf = 1'b1;
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
        check("ovf_clr_with_drop", 32'(overflow), 1);
        check("ovf_level_hold", 32'(frame_level), 8);
        @(posedge sys_clk);
        #1 clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        build_packet(2'b11);
        build_packet(2'b11);
        drain(1'b0);
        check("level_after_ovf", 32'(frame_level), 0);
        // Enough packets to wrap the sequence byte
        for (int p = 0; p < 257; p++) begin
            repeat (4) push_frame(17'(p), 17'(~p));
            build_packet(2'b11);
            drain(1'b0);
        end
        check("seq_model_wrapped", 32'(seq_m), 8);
        // Asynchronous reset in the middle of the payload
        repeat (4) push_frame(17'h1F0F0, 17'h00F0F);
        build_packet(2'b11);
        wait_sof();
        repeat (8) @(posedge sys_clk);
        #2 rst_n = 1'b0;
        #1 check_reset("midpkt_reset");
        exp_q.delete();
        mfifo.delete();
        seq_m = 8'd0;
        in_pkt = 1'b0;
        gap = 1'b0;
        hold_v = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (4) push_frame(17'h00002, 17'h10001);
        build_packet(2'b11);
        drain(1'b0);
        check("level_after_reset_pkt", 32'(frame_level), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
